// File: rtl/multiword_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multiword_add_ctrl
// Description : Adds two WIDTH*CHUNKS-bit operands one chunk per clock
//               through a single WIDTH-bit adder stage, LSB chunk first.
// Revision    : 1.0 - initial release
// ============================================================================
module multiword_add_ctrl #(
    parameter int WIDTH  = 8,
    parameter int CHUNKS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH*CHUNKS-1:0] a,
    input  logic [WIDTH*CHUNKS-1:0] b,
    input  logic                    c_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH*CHUNKS-1:0] sum,
    output logic                    c_out
);

    localparam int N     = WIDTH * CHUNKS;
    localparam int IDX_W = ($clog2(CHUNKS) < 1) ? 1 : $clog2(CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic [WIDTH:0]   w_chunk_sum;
    logic             w_accept;
    logic             w_last;
    logic             w_in_ready_nxt;
    logic             w_out_valid_nxt;

    // in_ready is registered, so acceptance also requires it to be asserted
    assign w_accept = (r_state == S_IDLE) && in_valid && in_ready;
    assign w_last   = (r_idx == LAST_IDX);

    // The only carry path between chunks is r_carry
    assign w_chunk_sum = {1'b0, r_a[int'(r_idx)*WIDTH +: WIDTH]}
                       + {1'b0, r_b[int'(r_idx)*WIDTH +: WIDTH]}
                       + (WIDTH+1)'(r_carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_carry   <= 1'b0;
        end else begin
            in_ready  <= w_in_ready_nxt;
            out_valid <= w_out_valid_nxt;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= c_in;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                sum[int'(r_idx)*WIDTH +: WIDTH] <= w_chunk_sum[WIDTH-1:0];
                r_carry <= w_chunk_sum[WIDTH];
                if (w_last) begin
                    c_out <= w_chunk_sum[WIDTH];
                    r_idx <= '0;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
